// File: rtl/ip_pkg.sv
// ip_pkg: shared types, constants and ones-complement helpers for the IPv4 receive path.
// Contents: FSM state encoding, IPv4 field constants, csum_fold (32->16 end-around fold),
//           is_l4_csum_prot (protocols whose transport checksum uses the pseudo-header sum).
package ip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_SKIP    = 2'd3
  } rx_state_e;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IHL_MIN      = 4'd5;
  localparam logic [7:0] PROT_TCP     = 8'd6;
  localparam logic [7:0] PROT_UDP     = 8'd17;

  // Two end-around folds are always enough: the first leaves at most 17 bits,
  // and when it carries the low half is small enough that the second cannot.
  function automatic logic [15:0] csum_fold(input logic [31:0] x);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, x[31:16]} + {1'b0, x[15:0]};
    s2 = s1[15:0] + {15'd0, s1[16]};
    return s2;
  endfunction

  function automatic logic is_l4_csum_prot(input logic [7:0] prot);
    return (prot == PROT_TCP) || (prot == PROT_UDP);
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// ip_csum_acc: 16-bit ones-complement accumulator, adds both halves of a 32-bit word per cycle.
// Ports: clr_i restarts the sum (combined with add_i it loads the current word), add_i adds data_i,
//        sum_o is the folded sum INCLUDING this cycle's word, so the caller can judge it in the same cycle.
module ip_csum_acc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [31:0] data_i,
  output logic [15:0] sum_o
);

  logic [15:0] acc_q, acc_d;
  logic [15:0] base;
  logic [19:0] raw;

  always_comb begin
    base  = clr_i ? 16'd0 : acc_q;
    raw   = {4'd0, base} + {4'd0, data_i[31:16]} + {4'd0, data_i[15:0]};
    acc_d = add_i ? csum_fold({12'd0, raw}) : base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 16'd0;
    else        acc_q <= acc_d;
  end

  assign sum_o = acc_d;

endmodule

// File: rtl/ip_rx_layer.sv
// ip_rx_layer: IPv4 receive stage; parses/validates the header, strips header+options, forwards payload.
// Latency: payload words appear 1 cycle after acceptance; header outputs update 1 cycle after the last header word.
// Flow: no backpressure (in_op_i qualifies input words); outputs rcv_* word stream, header fields, trunc_err_o, drop_cnt_o.
module ip_rx_layer
  import ip_pkg::*;
#(
  parameter bit DROP_FRAGMENTS = 1'b1,
  parameter bit CHECK_HEAD_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_op_st_i,
  input  logic        in_op_i,
  input  logic        in_op_end_i,
  input  logic [31:0] in_data_i,
  output logic        rcv_op_st_o,
  output logic        rcv_op_o,
  output logic        rcv_op_end_o,
  output logic [31:0] rcv_data_o,
  output logic [15:0] rcv_data_len_o,
  output logic [31:0] src_ip_addr_o,
  output logic [31:0] dst_ip_addr_o,
  output logic [7:0]  prot_type_o,
  output logic [15:0] pseudo_crc_sum_o,
  output logic        head_crc_ok_o,
  output logic        trunc_err_o,
  output logic [15:0] drop_cnt_o
);

  rx_state_e   state_q, state_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic [3:0]  ver_q, ver_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic        mf_q, mf_d;
  logic [12:0] frag_off_q, frag_off_d;
  logic [7:0]  prot_q, prot_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [14:0] remain_q, remain_d;
  logic        first_q, first_d;

  logic        rcv_st_q, rcv_st_d;
  logic        rcv_op_q, rcv_op_d;
  logic        rcv_end_q, rcv_end_d;
  logic [31:0] rcv_data_q, rcv_data_d;
  logic        trunc_q, trunc_d;
  logic [15:0] len_out_q, len_out_d;
  logic [31:0] src_out_q, src_out_d;
  logic [31:0] dst_out_q, dst_out_d;
  logic [7:0]  prot_out_q, prot_out_d;
  logic [15:0] pseudo_q, pseudo_d;
  logic        crc_ok_q, crc_ok_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        acc_clr, acc_add;
  logic [15:0] hdr_sum;
  logic [1:0]  drop_add;
  logic [16:0] drop_sum;
  logic        start;
  logic [3:0]  hdr_last_idx;
  logic [15:0] hdr_bytes;
  logic [15:0] pay_len;
  logic [16:0] pay_round;
  logic [31:0] dst_cur;
  logic [18:0] pseudo_raw;
  logic        hdr_bad;

  ip_csum_acc u_hdr_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (acc_clr),
    .add_i  (acc_add),
    .data_i (in_data_i),
    .sum_o  (hdr_sum)
  );

  // A short IHL is still walked to word 4 so the decision point is never before
  // the fields it inspects; such a header is dropped there anyway.
  assign hdr_last_idx = (ihl_q < IHL_MIN) ? 4'd4 : ihl_q - 4'd1;
  assign hdr_bytes    = {10'd0, ihl_q, 2'b00};
  assign pay_len      = tot_len_q - hdr_bytes;
  assign pay_round    = {1'b0, pay_len} + 17'd3;
  // The destination word may be the one being accepted right now (IHL=5).
  assign dst_cur      = (word_cnt_q == 4'd4) ? in_data_i : dst_q;
  assign pseudo_raw   = {3'd0, src_q[31:16]} + {3'd0, src_q[15:0]}
                      + {3'd0, dst_cur[31:16]} + {3'd0, dst_cur[15:0]}
                      + {11'd0, prot_q} + {3'd0, pay_len};
  assign hdr_bad      = (ver_q != IPV4_VERSION) || (ihl_q < IHL_MIN) || (tot_len_q < hdr_bytes)
                      || (CHECK_HEAD_CRC && (hdr_sum != 16'hFFFF))
                      || (DROP_FRAGMENTS && (mf_q || (frag_off_q != 13'd0)));
  assign start        = in_op_i & in_op_st_i;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    ver_d      = ver_q;
    ihl_d      = ihl_q;
    tot_len_d  = tot_len_q;
    mf_d       = mf_q;
    frag_off_d = frag_off_q;
    prot_d     = prot_q;
    src_d      = src_q;
    dst_d      = dst_q;
    remain_d   = remain_q;
    first_d    = first_q;
    len_out_d  = len_out_q;
    src_out_d  = src_out_q;
    dst_out_d  = dst_out_q;
    prot_out_d = prot_out_q;
    pseudo_d   = pseudo_q;
    crc_ok_d   = crc_ok_q;
    rcv_st_d   = 1'b0;
    rcv_op_d   = 1'b0;
    rcv_end_d  = 1'b0;
    rcv_data_d = 32'd0;
    trunc_d    = 1'b0;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    drop_add   = 2'd0;

    if (start) begin
      // A new frame start overrides whatever was in flight.
      if (state_q == ST_HEADER) drop_add = drop_add + 2'd1;
      if (state_q == ST_PAYLOAD) begin
        rcv_op_d  = 1'b1;
        rcv_end_d = 1'b1;
        trunc_d   = 1'b1;
      end
      ver_d      = in_data_i[31:28];
      ihl_d      = in_data_i[27:24];
      tot_len_d  = in_data_i[15:0];
      word_cnt_d = 4'd1;
      acc_clr    = 1'b1;
      acc_add    = 1'b1;
      state_d    = ST_HEADER;
      if (in_op_end_i) begin
        state_d  = ST_IDLE;
        drop_add = drop_add + 2'd1;
      end
    end else if (in_op_i) begin
      unique case (state_q)
        ST_HEADER: begin
          acc_add    = 1'b1;
          word_cnt_d = word_cnt_q + 4'd1;
          // Standard IPv4 layout: flags/offset live in word 1, protocol in word 2.
          case (word_cnt_q)
            4'd1: begin
              mf_d       = in_data_i[13];
              frag_off_d = in_data_i[12:0];
            end
            4'd2: prot_d = in_data_i[23:16];
            4'd3: src_d  = in_data_i;
            4'd4: dst_d  = in_data_i;
            default: ;
          endcase
          if (word_cnt_q == hdr_last_idx) begin
            src_out_d  = src_q;
            dst_out_d  = dst_cur;
            prot_out_d = prot_q;
            len_out_d  = pay_len;
            pseudo_d   = csum_fold({13'd0, pseudo_raw});
            crc_ok_d   = (hdr_sum == 16'hFFFF);
            if (hdr_bad) begin
              drop_add = 2'd1;
              state_d  = in_op_end_i ? ST_IDLE : ST_SKIP;
            end else if (pay_len == 16'd0) begin
              state_d  = in_op_end_i ? ST_IDLE : ST_SKIP;
            end else if (in_op_end_i) begin
              drop_add = 2'd1;
              state_d  = ST_IDLE;
            end else begin
              remain_d = pay_round[16:2];
              first_d  = 1'b1;
              state_d  = ST_PAYLOAD;
            end
          end else if (in_op_end_i) begin
            drop_add = 2'd1;
            state_d  = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          rcv_op_d   = 1'b1;
          rcv_data_d = in_data_i;
          rcv_st_d   = first_q;
          first_d    = 1'b0;
          remain_d   = remain_q - 15'd1;
          if (remain_q == 15'd1) begin
            rcv_end_d = 1'b1;
            state_d   = in_op_end_i ? ST_IDLE : ST_SKIP;
          end else if (in_op_end_i) begin
            rcv_end_d = 1'b1;
            trunc_d   = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (in_op_end_i) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end

    drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_add};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= 4'd0;
      ver_q      <= 4'd0;
      ihl_q      <= 4'd0;
      tot_len_q  <= 16'd0;
      mf_q       <= 1'b0;
      frag_off_q <= 13'd0;
      prot_q     <= 8'd0;
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      remain_q   <= 15'd0;
      first_q    <= 1'b0;
      rcv_st_q   <= 1'b0;
      rcv_op_q   <= 1'b0;
      rcv_end_q  <= 1'b0;
      rcv_data_q <= 32'd0;
      trunc_q    <= 1'b0;
      len_out_q  <= 16'd0;
      src_out_q  <= 32'd0;
      dst_out_q  <= 32'd0;
      prot_out_q <= 8'd0;
      pseudo_q   <= 16'd0;
      crc_ok_q   <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      ver_q      <= ver_d;
      ihl_q      <= ihl_d;
      tot_len_q  <= tot_len_d;
      mf_q       <= mf_d;
      frag_off_q <= frag_off_d;
      prot_q     <= prot_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      remain_q   <= remain_d;
      first_q    <= first_d;
      rcv_st_q   <= rcv_st_d;
      rcv_op_q   <= rcv_op_d;
      rcv_end_q  <= rcv_end_d;
      rcv_data_q <= rcv_data_d;
      trunc_q    <= trunc_d;
      len_out_q  <= len_out_d;
      src_out_q  <= src_out_d;
      dst_out_q  <= dst_out_d;
      prot_out_q <= prot_out_d;
      pseudo_q   <= pseudo_d;
      crc_ok_q   <= crc_ok_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rcv_op_st_o      = rcv_st_q;
  assign rcv_op_o         = rcv_op_q;
  assign rcv_op_end_o     = rcv_end_q;
  assign rcv_data_o       = rcv_data_q;
  assign trunc_err_o      = trunc_q;
  assign rcv_data_len_o   = len_out_q;
  assign src_ip_addr_o    = src_out_q;
  assign dst_ip_addr_o    = dst_out_q;
  assign prot_type_o      = prot_out_q;
  assign pseudo_crc_sum_o = pseudo_q;
  assign head_crc_ok_o    = crc_ok_q;
  assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_ip_rx_layer.sv
// tb_ip_rx_layer: scoreboard bench for ip_rx_layer.
// Expected payload words are queued as frames are driven and compared as the DUT emits them;
// header outputs and the drop counter are compared against a small ones-complement model.
module tb_ip_rx_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_op_st_i, in_op_i, in_op_end_i;
  logic [31:0] in_data_i;
  logic        rcv_op_st_o, rcv_op_o, rcv_op_end_o, trunc_err_o, head_crc_ok_o;
  logic [31:0] rcv_data_o, src_ip_addr_o, dst_ip_addr_o;
  logic [15:0] rcv_data_len_o, pseudo_crc_sum_o, drop_cnt_o;
  logic [7:0]  prot_type_o;

  ip_rx_layer #(.DROP_FRAGMENTS(1'b1), .CHECK_HEAD_CRC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_op_st_i(in_op_st_i), .in_op_i(in_op_i), .in_op_end_i(in_op_end_i), .in_data_i(in_data_i),
    .rcv_op_st_o(rcv_op_st_o), .rcv_op_o(rcv_op_o), .rcv_op_end_o(rcv_op_end_o), .rcv_data_o(rcv_data_o),
    .rcv_data_len_o(rcv_data_len_o), .src_ip_addr_o(src_ip_addr_o), .dst_ip_addr_o(dst_ip_addr_o),
    .prot_type_o(prot_type_o), .pseudo_crc_sum_o(pseudo_crc_sum_o), .head_crc_ok_o(head_crc_ok_o),
    .trunc_err_o(trunc_err_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        en;
    logic        tr;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] frm[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          drop_exp = 0;
  bit          mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [15:0] pseudo_model(input logic [31:0] s, input logic [31:0] d,
                                               input logic [7:0] p, input logic [15:0] len);
    logic [15:0] acc;
    acc = oc_add(s[31:16], s[15:0]);
    acc = oc_add(acc, d[31:16]);
    acc = oc_add(acc, d[15:0]);
    acc = oc_add(acc, {8'h00, p});
    acc = oc_add(acc, len);
    return acc;
  endfunction

  // Builds an IPv4 frame into frm: header (with correct checksum unless bad_csum), options, then filler words.
  task automatic build_pkt(input logic [3:0] ihl, input logic [15:0] tot, input logic [15:0] flags_off,
                           input logic [7:0] prot, input logic [31:0] src, input logic [31:0] dst,
                           input int nwords, input bit bad_csum);
    logic [15:0] sum;
    frm.delete();
    frm.push_back({4'd4, ihl, 8'h00, tot});
    frm.push_back({16'h1234, flags_off});
    frm.push_back({8'h40, prot, 16'h0000});
    frm.push_back(src);
    frm.push_back(dst);
    for (int i = 5; i < int'(ihl); i++) frm.push_back(32'hA5A50000 + i);
    sum = 16'h0000;
    for (int i = 0; i < int'(ihl); i++) sum = oc_add(oc_add(sum, frm[i][31:16]), frm[i][15:0]);
    frm[2][15:0] = ~sum;
    if (bad_csum) frm[2][7:0] = frm[2][7:0] ^ 8'hFF;
    for (int i = int'(ihl); i < nwords; i++) frm.push_back(32'hD0000000 + (i << 8) + $urandom_range(0, 255));
  endtask

  task automatic expect_payload(input int first, input int cnt, input bit trunc_last);
    exp_t e;
    for (int k = 0; k < cnt; k++) begin
      e.st = (k == 0);
      e.en = (k == cnt - 1);
      e.tr = trunc_last && (k == cnt - 1);
      e.d  = frm[first + k];
      exp_q.push_back(e);
    end
  endtask

  // Drives frm[lo..hi-1]; st on the first word if st_first, end on the last if with_end; random bubbles.
  task automatic send_rng(input int lo, input int hi, input bit st_first, input bit with_end);
    for (int i = lo; i < hi; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      in_op_i     = 1'b1;
      in_op_st_i  = st_first && (i == lo);
      in_op_end_i = with_end && (i == hi - 1);
      in_data_i   = frm[i];
      @(posedge clk); #1;
      in_op_i = 1'b0; in_op_st_i = 1'b0; in_op_end_i = 1'b0; in_data_i = 32'h0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_hdr(input string tag, input logic [31:0] src, input logic [31:0] dst,
                           input logic [7:0] prot, input logic [15:0] len, input bit ok);
    check_eq({tag, "_src"}, src_ip_addr_o, src);
    check_eq({tag, "_dst"}, dst_ip_addr_o, dst);
    check_eq({tag, "_prot"}, prot_type_o, prot);
    check_eq({tag, "_len"}, rcv_data_len_o, len);
    check_eq({tag, "_pseudo"}, pseudo_crc_sum_o, pseudo_model(src, dst, prot, len));
    check_eq({tag, "_crc_ok"}, head_crc_ok_o, ok);
    check_eq({tag, "_drop"}, drop_cnt_o, drop_exp);
    check_eq({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rcv_op_o) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", {rcv_op_o, rcv_op_st_o, rcv_op_end_o, trunc_err_o, rcv_data_o}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("payload_word", {rcv_op_st_o, rcv_op_end_o, trunc_err_o, rcv_data_o}, mon_e);
        end
      end else begin
        check_eq("idle_quiet", {rcv_op_st_o, rcv_op_end_o, trunc_err_o, rcv_data_o}, 64'd0);
      end
    end
  end

  localparam logic [31:0] SRC_A = 32'hC0A8010A;
  localparam logic [31:0] DST_A = 32'hC0A80164;
  localparam logic [31:0] SRC_B = 32'h0A000001;
  localparam logic [31:0] DST_B = 32'hAC100203;

  initial begin
    rst_n = 1'b0;
    in_op_i = 1'b0; in_op_st_i = 1'b0; in_op_end_i = 1'b0; in_data_i = 32'h0;
    idle(3);
    check_eq("reset_outputs",
             {rcv_op_st_o, rcv_op_o, rcv_op_end_o, trunc_err_o, head_crc_ok_o, rcv_data_o}, 64'd0);
    check_eq("reset_hdr", {src_ip_addr_o, dst_ip_addr_o}, 64'd0);
    check_eq("reset_misc", {prot_type_o, rcv_data_len_o, pseudo_crc_sum_o, drop_cnt_o}, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Basic TCP packet, 3 payload words
    build_pkt(4'd5, 16'h0020, 16'h4000, 8'd6, SRC_A, DST_A, 8, 1'b0);
    expect_payload(5, 3, 1'b0);
    send_rng(0, 8, 1'b1, 1'b1);
    idle(4);
    check_hdr("basic", SRC_A, DST_A, 8'd6, 16'h000C, 1'b1);
    check_eq("basic_pseudo_const", pseudo_crc_sum_o, 16'h83D1);

    // Padded minimum Ethernet frame: 2 payload words, padding discarded
    build_pkt(4'd5, 16'h001C, 16'h0000, 8'd6, SRC_B, DST_B, 12, 1'b0);
    expect_payload(5, 2, 1'b0);
    send_rng(0, 12, 1'b1, 1'b1);
    idle(4);
    check_hdr("padded", SRC_B, DST_B, 8'd6, 16'h0008, 1'b1);

    // Corrupted header checksum is dropped
    build_pkt(4'd5, 16'h0020, 16'h0000, 8'd6, SRC_A, DST_A, 8, 1'b1);
    drop_exp++;
    send_rng(0, 8, 1'b1, 1'b1);
    idle(4);
    check_hdr("bad_csum", SRC_A, DST_A, 8'd6, 16'h000C, 1'b0);

    // One option word; single-word payload
    build_pkt(4'd6, 16'h001C, 16'h0000, 8'd17, SRC_B, DST_A, 12, 1'b0);
    expect_payload(6, 1, 1'b0);
    send_rng(0, 12, 1'b1, 1'b1);
    idle(4);
    check_hdr("options", SRC_B, DST_A, 8'd17, 16'h0004, 1'b1);

    // Frame ends on the 2nd of 3 payload words, then a normal packet follows
    build_pkt(4'd5, 16'h0020, 16'h0000, 8'd6, SRC_A, DST_B, 7, 1'b0);
    expect_payload(5, 2, 1'b1);
    send_rng(0, 7, 1'b1, 1'b1);
    idle(3);
    build_pkt(4'd5, 16'h0020, 16'h0000, 8'd6, SRC_B, DST_B, 8, 1'b0);
    expect_payload(5, 3, 1'b0);
    send_rng(0, 8, 1'b1, 1'b1);
    idle(4);
    check_hdr("after_trunc", SRC_B, DST_B, 8'd6, 16'h000C, 1'b1);

    // MF=1 fragment is dropped
    build_pkt(4'd5, 16'h0020, 16'h2000, 8'd6, SRC_A, DST_A, 8, 1'b0);
    drop_exp++;
    send_rng(0, 8, 1'b1, 1'b1);
    idle(4);
    check_hdr("fragment", SRC_A, DST_A, 8'd6, 16'h000C, 1'b1);

    // Non-zero fragment offset is dropped too
    build_pkt(4'd5, 16'h0020, 16'h0010, 8'd6, SRC_B, DST_A, 8, 1'b0);
    drop_exp++;
    send_rng(0, 8, 1'b1, 1'b1);
    idle(4);
    check_hdr("frag_off", SRC_B, DST_A, 8'd6, 16'h000C, 1'b1);

    // Zero-length payload: nothing forwarded, not a drop
    build_pkt(4'd5, 16'h0014, 16'h0000, 8'd17, SRC_A, DST_B, 12, 1'b0);
    send_rng(0, 12, 1'b1, 1'b1);
    idle(4);
    check_hdr("zero_len", SRC_A, DST_B, 8'd17, 16'h0000, 1'b1);

    // Restart while in PAYLOAD: abort marker word, then the new frame parses normally
    build_pkt(4'd5, 16'h0020, 16'h0000, 8'd6, SRC_A, DST_A, 8, 1'b0);
    expect_payload(5, 1, 1'b0);
    exp_q[exp_q.size() - 1].en = 1'b0;
    send_rng(0, 6, 1'b1, 1'b0);
    exp_q.push_back('{st: 1'b0, en: 1'b1, tr: 1'b1, d: 32'h0});
    build_pkt(4'd5, 16'h0020, 16'h0000, 8'd6, SRC_B, DST_A, 8, 1'b0);
    expect_payload(5, 3, 1'b0);
    send_rng(0, 8, 1'b1, 1'b1);
    idle(4);
    check_hdr("restart_payload", SRC_B, DST_A, 8'd6, 16'h000C, 1'b1);

    // Restart while in HEADER counts one drop
    build_pkt(4'd5, 16'h0020, 16'h0000, 8'd6, SRC_A, DST_B, 8, 1'b0);
    send_rng(0, 3, 1'b1, 1'b0);
    drop_exp++;
    expect_payload(5, 3, 1'b0);
    send_rng(0, 8, 1'b1, 1'b1);
    idle(4);
    check_hdr("restart_header", SRC_A, DST_B, 8'd6, 16'h000C, 1'b1);

    // Asynchronous reset mid-frame; the remainder of the frame is ignored
    build_pkt(4'd5, 16'h0020, 16'h0000, 8'd6, SRC_B, DST_B, 8, 1'b0);
    send_rng(0, 3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    drop_exp = 0;
    #1;
    check_eq("midreset_drop", drop_cnt_o, 16'd0);
    check_eq("midreset_hdr", src_ip_addr_o, 32'd0);
    idle(1);
    rst_n = 1'b1;
    send_rng(3, 8, 1'b0, 1'b1);
    idle(4);
    check_eq("post_reset_drop", drop_cnt_o, drop_exp);
    check_eq("post_reset_sb", exp_q.size(), 0);

    // Drop counter saturation using one-word frames (start and end together)
    in_op_i = 1'b1; in_op_st_i = 1'b1; in_op_end_i = 1'b1; in_data_i = 32'h45000014;
    repeat (65535 - drop_exp) @(posedge clk);
    #1;
    in_op_i = 1'b0; in_op_st_i = 1'b0; in_op_end_i = 1'b0; in_data_i = 32'h0;
    drop_exp = 65535;
    idle(1);
    check_eq("sat_reach", drop_cnt_o, drop_exp);
    in_op_i = 1'b1; in_op_st_i = 1'b1; in_op_end_i = 1'b1; in_data_i = 32'h45000014;
    idle(1);
    in_op_i = 1'b0; in_op_st_i = 1'b0; in_op_end_i = 1'b0; in_data_i = 32'h0;
    idle(2);
    check_eq("sat_hold", drop_cnt_o, 16'hFFFF);
    check_eq("final_sb", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
